// File: rtl/fm_iv_wr_buf.sv
// Frame-memory input-video write buffer.
// Collects 16-pixel bursts from the video input stage into a two-entry
// ping-pong buffer and hands each full burst to the frame-memory arbiter
// as a req/ack-gated 16-beat write. Bad or overflowing bursts are dropped.
module fm_iv_wr_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] din,
    input  logic        din_we,
    input  logic [16:0] din_adrs,
    output logic        wr_req,
    output logic [16:0] wr_adrs,
    input  logic        wr_ack,
    output logic [29:0] wr_data,
    output logic        wr_dv,
    output logic        wr_last,
    output logic [1:0]  buf_cnt,
    output logic        ovf,
    input  logic        ovf_clr,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISC} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_XFER} rstate_t;

    logic [29:0]      mem [2][16];
    logic [1:0]       full, full_nxt;
    logic [1:0][12:0] base;
    logic             wsel, rsel;
    wstate_t          ws, ws_nxt;
    rstate_t          rs, rs_nxt;
    logic [3:0]       wexp, wexp_nxt;
    logic [3:0]       bcnt;

    logic [3:0]       idx;
    logic [12:0]      hi;
    logic             start, wr_en, latch_base, w_done, abort, ovf_set, drop_inc;
    logic             rd_issue, rd_done, avail_r, avail_o;
    logic [3:0]       rd_addr;

    assign idx      = din_adrs[3:0];
    assign hi       = din_adrs[16:4];
    assign drop_inc = abort | ovf_set;

    // Write FSM: accept in-order beats of one burst, abort on any mismatch,
    // and treat an idx=0 beat as a fresh start from any state.
    always_comb begin
        ws_nxt     = ws;
        wexp_nxt   = wexp;
        start      = 1'b0;
        wr_en      = 1'b0;
        latch_base = 1'b0;
        w_done     = 1'b0;
        abort      = 1'b0;
        ovf_set    = 1'b0;
        case (ws)
            W_IDLE: begin
                if (din_we && idx == 4'd0) start = 1'b1;
            end
            W_FILL: begin
                if (din_we) begin
                    if (idx == wexp && hi == base[wsel]) begin
                        wr_en    = 1'b1;
                        wexp_nxt = wexp + 4'd1;
                        if (idx == 4'd15) begin
                            w_done = 1'b1;
                            ws_nxt = W_IDLE;
                        end
                    end else begin
                        abort  = 1'b1;
                        ws_nxt = W_IDLE;
                        if (idx == 4'd0) start = 1'b1;
                    end
                end
            end
            W_DISC: begin
                if (din_we) begin
                    if (idx == 4'd0)       start  = 1'b1;
                    else if (idx == 4'd15) ws_nxt = W_IDLE;
                end
            end
            default: ws_nxt = W_IDLE;
        endcase
        // A start into a buffer still held (even during its last readout beat)
        // overflows and the rest of that burst is discarded.
        if (start) begin
            if (!full[wsel]) begin
                wr_en      = 1'b1;
                latch_base = 1'b1;
                wexp_nxt   = 4'd1;
                ws_nxt     = W_FILL;
            end else begin
                ovf_set = 1'b1;
                ws_nxt  = W_DISC;
            end
        end
    end

    // A buffer is ready for readout if already full or completing this cycle,
    // so the request can go out the cycle right after the last fill beat.
    assign avail_r = full[rsel]  | (w_done & (wsel == rsel));
    assign avail_o = full[~rsel] | (w_done & (wsel != rsel));

    // Read FSM: request, wait for grant, then stream 16 words from storage.
    always_comb begin
        rs_nxt   = rs;
        rd_issue = 1'b0;
        rd_addr  = 4'd0;
        rd_done  = 1'b0;
        case (rs)
            R_IDLE: begin
                if (avail_r) rs_nxt = R_REQ;
            end
            R_REQ: begin
                if (wr_ack) begin
                    rs_nxt   = R_XFER;
                    rd_issue = 1'b1;
                end
            end
            R_XFER: begin
                if (bcnt == 4'd15) begin
                    rd_done = 1'b1;
                    rs_nxt  = avail_o ? R_REQ : R_IDLE;
                end else begin
                    rd_issue = 1'b1;
                    rd_addr  = bcnt + 4'd1;
                end
            end
            default: rs_nxt = R_IDLE;
        endcase
    end

    // Full flags: the write side and read side never touch the same buffer
    // in one cycle, so set and clear are independent.
    always_comb begin
        full_nxt = full;
        if (rd_done) full_nxt[rsel] = 1'b0;
        if (w_done)  full_nxt[wsel] = 1'b1;
    end

    // Pixel storage; contents need no reset since full flags gate their use.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wsel][idx] <= din;
    end

    // Control state, pointers, counters and the registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            ws       <= W_IDLE;
            rs       <= R_IDLE;
            full     <= '0;
            base     <= '0;
            wsel     <= 1'b0;
            rsel     <= 1'b0;
            wexp     <= '0;
            bcnt     <= '0;
            buf_cnt  <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
            wr_data  <= '0;
        end else begin
            ws      <= ws_nxt;
            rs      <= rs_nxt;
            full    <= full_nxt;
            wexp    <= wexp_nxt;
            buf_cnt <= {1'b0, full_nxt[0]} + {1'b0, full_nxt[1]};
            if (latch_base) base[wsel] <= hi;
            if (w_done)     wsel <= ~wsel;
            if (rd_done)    rsel <= ~rsel;
            if (rs == R_REQ && wr_ack) bcnt <= 4'd0;
            else if (rs == R_XFER)     bcnt <= bcnt + 4'd1;
            if (rd_issue) wr_data <= mem[rsel][rd_addr];
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
            if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign wr_req  = (rs == R_REQ);
    assign wr_adrs = wr_req ? {base[rsel], 4'h0} : 17'd0;
    assign wr_dv   = (rs == R_XFER);
    assign wr_last = wr_dv && (bcnt == 4'd15);

endmodule

// File: tb/tb_fm_iv_wr_buf.sv
// Directed bench for fm_iv_wr_buf: bursts are queued on a scoreboard as they
// are written, and every wr_dv beat is popped and compared as it appears.
module tb_fm_iv_wr_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] din;
    logic        din_we;
    logic [16:0] din_adrs;
    logic        wr_req;
    logic [16:0] wr_adrs;
    logic        wr_ack;
    logic [29:0] wr_data;
    logic        wr_dv;
    logic        wr_last;
    logic [1:0]  buf_cnt;
    logic        ovf;
    logic        ovf_clr;
    logic [7:0]  drop_cnt;

    typedef struct packed {
        logic [29:0] d;
        logic        l;
    } beat_t;

    beat_t sb[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    always #4 clk = ~clk;

    fm_iv_wr_buf dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_we   (din_we),
        .din_adrs (din_adrs),
        .wr_req   (wr_req),
        .wr_adrs  (wr_adrs),
        .wr_ack   (wr_ack),
        .wr_data  (wr_data),
        .wr_dv    (wr_dv),
        .wr_last  (wr_last),
        .buf_cnt  (buf_cnt),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .drop_cnt (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge, beats scored here.
    task automatic tick();
        beat_t e;
        @(posedge clk);
        @(negedge clk);
        if (wr_dv === 1'b1) begin
            check("beat_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("wr_data", 32'(wr_data), 32'(e.d));
                check("wr_last", 32'(wr_last), 32'(e.l));
            end
        end
    endtask

    task automatic write_beat(input logic [16:0] a, input logic [29:0] d);
        din_adrs = a;
        din      = d;
        din_we   = 1'b1;
        tick();
        din_we   = 1'b0;
    endtask

    task automatic send_burst(input logic [12:0] b, input logic [29:0] seed, input bit push);
        beat_t e;
        logic [29:0] d;
        for (int i = 0; i < 16; i++) begin
            d = seed + 30'(i * 3);
            write_beat({b, 4'(i)}, d);
            if (push) begin
                e.d = d;
                e.l = (i == 15);
                sb.push_back(e);
            end
        end
    endtask

    task automatic partial(input logic [12:0] b, input int n);
        for (int i = 0; i < n; i++) write_beat({b, 4'(i)}, 30'(i + 7));
    endtask

    // Grant the pending request after dly cycles; returns at T+17.
    task automatic do_xfer(input logic [16:0] a, input int dly);
        int k = 0;
        while (wr_req !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check("req_seen", 32'(wr_req), 32'd1);
        check("wr_adrs", 32'(wr_adrs), 32'(a));
        repeat (dly) tick();
        check("req_held", 32'(wr_req), 32'd1);
        check("adrs_held", 32'(wr_adrs), 32'(a));
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check("req_drop", 32'(wr_req), 32'd0);
        check("dv_first", 32'(wr_dv), 32'd1);
        repeat (15) tick();
        check("last_beat", 32'(wr_last), 32'd1);
        tick();
        check("dv_end", 32'(wr_dv), 32'd0);
    endtask

    initial begin
        rst = 1'b1; din = '0; din_we = 1'b0; din_adrs = '0; wr_ack = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_req", 32'(wr_req), 32'd0);
        check("rst_adrs", 32'(wr_adrs), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("rst_dv", 32'(wr_dv), 32'd0);
        check("rst_last", 32'(wr_last), 32'd0);
        check("rst_bufcnt", 32'(buf_cnt), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        tick();

        // 1: single burst, request the cycle after the last fill beat
        send_burst(13'h1A3, 30'd0, 1'b1);
        check("t1_req_lat", 32'(wr_req), 32'd1);
        check("t1_bufcnt1", 32'(buf_cnt), 32'd1);
        do_xfer(17'h1A30, 5);
        check("t1_bufcnt0", 32'(buf_cnt), 32'd0);
        check("t1_drop", 32'(drop_cnt), 32'd0);

        // 2: ping-pong, second request right at T+17
        send_burst(13'h000, 30'd100, 1'b1);
        send_burst(13'h001, 30'd200, 1'b1);
        check("t2_bufcnt2", 32'(buf_cnt), 32'd2);
        do_xfer(17'h00000, 2);
        check("t2_req_t17", 32'(wr_req), 32'd1);
        check("t2_adrs_t17", 32'(wr_adrs), 32'h0010);
        check("t2_bufcnt1", 32'(buf_cnt), 32'd1);
        do_xfer(17'h00010, 0);
        check("t2_bufcnt0", 32'(buf_cnt), 32'd0);

        // 3: overflow on a third start, discarded beats, then clear
        send_burst(13'h010, 30'd300, 1'b1);
        send_burst(13'h011, 30'd400, 1'b1);
        check("t3_bufcnt2", 32'(buf_cnt), 32'd2);
        send_burst(13'h012, 30'd500, 1'b0);
        check("t3_ovf", 32'(ovf), 32'd1);
        check("t3_drop", 32'(drop_cnt), 32'd1);
        check("t3_bufcnt", 32'(buf_cnt), 32'd2);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t3_ovf_clr", 32'(ovf), 32'd0);
        do_xfer(17'h00100, 1);
        do_xfer(17'h00110, 1);

        // 4: abort on a skipped index, then restart by an early idx=0
        partial(13'h020, 7);
        write_beat({13'h020, 4'd8}, 30'd99);
        tick();
        check("t4_drop", 32'(drop_cnt), 32'd2);
        check("t4_noreq", 32'(wr_req), 32'd0);
        check("t4_bufcnt", 32'(buf_cnt), 32'd0);
        partial(13'h021, 7);
        send_burst(13'h022, 30'd700, 1'b1);
        check("t4_drop2", 32'(drop_cnt), 32'd3);
        check("t4_bufcnt1", 32'(buf_cnt), 32'd1);
        do_xfer(17'h00220, 3);

        // 5: reset on the 8th readout beat
        send_burst(13'h030, 30'd800, 1'b1);
        wr_ack = 1'b0;
        repeat (2) tick();
        check("t5_req", 32'(wr_req), 32'd1);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        repeat (7) tick();
        check("t5_dv8", 32'(wr_dv), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("t5_dv", 32'(wr_dv), 32'd0);
        check("t5_req0", 32'(wr_req), 32'd0);
        check("t5_adrs", 32'(wr_adrs), 32'd0);
        check("t5_data", 32'(wr_data), 32'd0);
        check("t5_last", 32'(wr_last), 32'd0);
        check("t5_bufcnt", 32'(buf_cnt), 32'd0);
        check("t5_drop", 32'(drop_cnt), 32'd0);
        send_burst(13'h031, 30'd900, 1'b1);
        do_xfer(17'h00310, 4);

        // 6: drop counter saturation
        for (int i = 0; i < 300; i++) begin
            write_beat({13'h040, 4'd0}, 30'd1);
            write_beat({13'h040, 4'd5}, 30'd2);
            if (i == 9) check("t6_drop10", 32'(drop_cnt), 32'd10);
        end
        check("t6_drop_sat", 32'(drop_cnt), 32'd255);
        check("t6_ovf", 32'(ovf), 32'd0);
        check("t6_noreq", 32'(wr_req), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
